// File: rtl/draw_sprite_regions.sv
// Multi-window bitmap overlay: per-region ROM addressing, latency-matched select pipeline,
// priority resolution and tinting. Optional blink gating is enabled with `define DRAW_BLINK_EN.
module draw_sprite_regions #(
    parameter int                         NUM_REGIONS = 3,
    parameter int                         ADDR_W      = 15,
    parameter int                         ROM_LAT     = 1,
    parameter logic [NUM_REGIONS*11-1:0]  REGION_X0   = {11'd413, 11'd413, 11'd246},
    parameter logic [NUM_REGIONS*10-1:0]  REGION_Y0   = {10'd259, 10'd137, 10'd44},
    parameter logic [NUM_REGIONS*11-1:0]  REGION_W    = {11'd237, 11'd88, 11'd303},
    parameter logic [NUM_REGIONS*10-1:0]  REGION_H    = {10'd119, 10'd88, 10'd40},
    parameter logic [NUM_REGIONS*3-1:0]   REGION_TINT = {3'b111, 3'b111, 3'b111},
    parameter logic [NUM_REGIONS-1:0]     BLINK_MASK  = '0,
    parameter int                         BLINK_LOG2  = 5
) (
    input  logic                          vga_clk,
    input  logic                          rst,
    input  logic [10:0]                   x,
    input  logic [9:0]                    y,
    input  logic                          frame_tick,
    input  logic [NUM_REGIONS-1:0]        region_en,
    output logic [NUM_REGIONS*ADDR_W-1:0] rom_addr,
    input  logic [NUM_REGIONS*2-1:0]      rom_data,
    output logic [1:0]                    r,
    output logic [1:0]                    g,
    output logic [1:0]                    b,
    output logic                          dav
);

    localparam int LAT   = 1 + ROM_LAT;
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic [11:0]            x12;
    logic [11:0]            y12;
    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS-1:0] hide;
    logic [NUM_REGIONS-1:0] eligible;

    assign x12 = {1'b0, x};
    assign y12 = {2'b00, y};

    // Per-region window decode and address counter.
    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        localparam logic [11:0] X0 = {1'b0, REGION_X0[i*11 +: 11]};
        localparam logic [11:0] X1 = X0 + {1'b0, REGION_W[i*11 +: 11]};
        localparam logic [11:0] Y0 = {2'b00, REGION_Y0[i*10 +: 10]};
        localparam logic [11:0] Y1 = Y0 + {2'b00, REGION_H[i*10 +: 10]};

        logic              row_in;
        logic              col_in;
        logic              frame_start;
        logic [ADDR_W-1:0] cnt_q;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] addr_q;

        assign row_in      = (y12 >= Y0) && (y12 < Y1);
        assign col_in      = (x12 >= X0) && (x12 < X1);
        assign hit[i]      = row_in && col_in;
        assign frame_start = (y12 == Y0) && (x == 11'd0);
        // A restart at x==0 must also serve a hit on that same pixel when X0 is 0.
        assign base        = frame_start ? '0 : cnt_q;

        always_ff @(posedge vga_clk) begin
            if (rst) begin
                cnt_q  <= '0;
                addr_q <= '0;
            end else if (!row_in) begin
                cnt_q  <= '0;
                addr_q <= '0;
            end else if (hit[i]) begin
                cnt_q  <= base + ADDR_W'(1);
                addr_q <= base;
            end else begin
                cnt_q  <= base;
                addr_q <= '0;
            end
        end

        assign rom_addr[i*ADDR_W +: ADDR_W] = addr_q;
    end

`ifdef DRAW_BLINK_EN
    logic [7:0] frame_cnt;
    logic       unused_cnt;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign hide       = frame_cnt[BLINK_LOG2] ? BLINK_MASK : '0;
    assign unused_cnt = ^frame_cnt;
`else
    logic unused_cfg;

    assign hide       = '0;
    assign unused_cfg = frame_tick ^ (^BLINK_MASK) ^ (BLINK_LOG2 == 0);
`endif

    // A hidden or disabled region drops out so a lower-priority region underneath shows through.
    assign eligible = hit & region_en & ~hide;

    logic [IDX_W-1:0] win_idx;
    logic             win_vld;

    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = IDX_W'(i);
                win_vld = 1'b1;
            end
        end
    end

    // Select pipeline: stage LAT-1 lines up with rom_data for the same pixel.
    logic [IDX_W-1:0] sel_idx [LAT];
    logic             sel_vld [LAT];

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                sel_idx[s] <= '0;
                sel_vld[s] <= 1'b0;
            end
        end else begin
            sel_idx[0] <= win_idx;
            sel_vld[0] <= win_vld;
            for (int s = 1; s < LAT; s++) begin
                sel_idx[s] <= sel_idx[s-1];
                sel_vld[s] <= sel_vld[s-1];
            end
        end
    end

    logic [1:0] pix;
    logic [2:0] tint;

    always_comb begin
        pix  = 2'b00;
        tint = 3'b000;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_idx[LAT-1] == IDX_W'(i)) begin
                pix  = rom_data[2*i +: 2];
                tint = REGION_TINT[3*i +: 3];
            end
        end
        dav = sel_vld[LAT-1];
        r   = (dav && tint[2]) ? pix : 2'b00;
        g   = (dav && tint[1]) ? pix : 2'b00;
        b   = (dav && tint[0]) ? pix : 2'b00;
    end

endmodule

// File: tb/tb_draw_sprite_regions.sv
// Directed bench for draw_sprite_regions: reset, addressing, alignment, priority/enable and tint,
// with a blink sequence when DRAW_BLINK_EN is defined.
module tb_draw_sprite_regions;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic [10:0] x;
    logic [9:0]  y;
    logic        frame_tick;
    logic [2:0]  region_en;
    logic [44:0] rom_addr;
    logic [44:0] p_rom_addr;
    logic [5:0]  rom_data;
    logic [5:0]  p_rom_data;
    logic [1:0]  r, g, b, p_r, p_g, p_b;
    logic        dav, p_dav;
    logic [1:0]  rom_q [3];

    always #5 vga_clk = ~vga_clk;

    draw_sprite_regions #(
        .BLINK_MASK (3'b001),
        .BLINK_LOG2 (1)
    ) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .region_en  (region_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .r          (r),
        .g          (g),
        .b          (b),
        .dav        (dav)
    );

    // Region 0 moved onto region 1 (416..423 x 138..141) with a red-only tint.
    draw_sprite_regions #(
        .REGION_X0   ({11'd413, 11'd413, 11'd416}),
        .REGION_Y0   ({10'd259, 10'd137, 10'd138}),
        .REGION_W    ({11'd237, 11'd88, 11'd8}),
        .REGION_H    ({10'd119, 10'd88, 10'd4}),
        .REGION_TINT ({3'b111, 3'b111, 3'b100})
    ) dut_p (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .region_en  (region_en),
        .rom_addr   (p_rom_addr),
        .rom_data   (p_rom_data),
        .r          (p_r),
        .g          (p_g),
        .b          (p_b),
        .dav        (p_dav)
    );

    // One-cycle ROM returning the low two address bits.
    always_ff @(posedge vga_clk) begin
        for (int i = 0; i < 3; i++) begin
            rom_q[i] <= rom_addr[i*15 +: 2];
        end
    end

    assign rom_data   = {rom_q[2], rom_q[1], rom_q[0]};
    assign p_rom_data = {2'b11, 2'b01, 2'b10};

    typedef struct {
        int          px;
        int          py;
        logic [2:0]  en;
        int          rg;
        logic [14:0] addr;
        logic        dav;
        logic [5:0]  rgb;
        logic        p_dav;
        logic [5:0]  p_rgb;
        logic [14:0] p_addr0;
    } vec_t;

    localparam int NT = 20;
    vec_t tbl [NT];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    function automatic int find(input int px, input int py);
        int k;
        k = -1;
        for (int i = 0; i < NT; i++) begin
            if (tbl[i].px == px && tbl[i].py == py) k = i;
        end
        return k;
    endfunction

    logic [14:0] max_a [3];
    int          k;
    int          prev;
    int          lo;
    int          hi;

    initial begin
        //            x    y    en     rg addr      dav rgb        pdav prgb       paddr0
        tbl[0]  = '{245,  44, 3'b111, 0, 15'd0,     0, 6'b000000, 0, 6'b000000, 15'd0};
        tbl[1]  = '{246,  44, 3'b111, 0, 15'd0,     1, 6'b000000, 0, 6'b000000, 15'd0};
        tbl[2]  = '{249,  44, 3'b111, 0, 15'd3,     1, 6'b111111, 0, 6'b000000, 15'd0};
        tbl[3]  = '{548,  44, 3'b111, 0, 15'd302,   1, 6'b101010, 0, 6'b000000, 15'd0};
        tbl[4]  = '{549,  44, 3'b111, 0, 15'd0,     0, 6'b000000, 0, 6'b000000, 15'd0};
        tbl[5]  = '{300,  60, 3'b111, 0, 15'd4902,  1, 6'b101010, 0, 6'b000000, 15'd0};
        tbl[6]  = '{548,  83, 3'b111, 0, 15'd12119, 1, 6'b111111, 0, 6'b000000, 15'd0};
        tbl[7]  = '{549,  83, 3'b111, 0, 15'd0,     0, 6'b000000, 0, 6'b000000, 15'd0};
        tbl[8]  = '{0,    84, 3'b111, 0, 15'd0,     0, 6'b000000, 0, 6'b000000, 15'd0};
        tbl[9]  = '{413, 137, 3'b111, 1, 15'd0,     1, 6'b000000, 1, 6'b010101, 15'd0};
        tbl[10] = '{420, 140, 3'b111, 1, 15'd271,   1, 6'b111111, 1, 6'b100000, 15'd20};
        tbl[11] = '{421, 140, 3'b110, 1, 15'd272,   1, 6'b000000, 1, 6'b010101, 15'd21};
        tbl[12] = '{422, 140, 3'b100, 1, 15'd273,   0, 6'b000000, 0, 6'b000000, 15'd22};
        tbl[13] = '{423, 140, 3'b111, 1, 15'd274,   1, 6'b101010, 1, 6'b100000, 15'd23};
        tbl[14] = '{423, 141, 3'b111, 1, 15'd362,   1, 6'b101010, 1, 6'b100000, 15'd31};
        tbl[15] = '{500, 224, 3'b111, 1, 15'd7743,  1, 6'b111111, 1, 6'b010101, 15'd0};
        tbl[16] = '{501, 224, 3'b111, 1, 15'd0,     0, 6'b000000, 0, 6'b000000, 15'd0};
        tbl[17] = '{413, 259, 3'b111, 2, 15'd0,     1, 6'b000000, 1, 6'b111111, 15'd0};
        tbl[18] = '{649, 377, 3'b111, 2, 15'd28202, 1, 6'b101010, 1, 6'b111111, 15'd0};
        tbl[19] = '{650, 377, 3'b111, 2, 15'd0,     0, 6'b000000, 0, 6'b000000, 15'd0};

        // Reset held with the pixel inside region 0.
        rst        = 1'b1;
        x          = 11'd300;
        y          = 10'd60;
        region_en  = 3'b111;
        frame_tick = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("rst_dav_%0d", c), 64'(dav), 64'd0);
            chk($sformatf("rst_rgb_%0d", c), 64'({r, g, b}), 64'd0);
            chk($sformatf("rst_addr_%0d", c), 64'(rom_addr), 64'd0);
        end
        rst = 1'b0;
        tick();
        chk("rel_dav_cycle1", 64'(dav), 64'd0);
        tick();
        chk("rel_dav_cycle2", 64'(dav), 64'd1);

        // Scan every row that any window touches, only over the columns near the windows.
        for (int i = 0; i < 3; i++) max_a[i] = '0;
        prev = -1;
        for (int yy = 40; yy <= 380; yy++) begin
            if (yy >= 44 && yy < 84) begin
                lo = 244; hi = 550;
            end else if (yy >= 137 && yy < 225) begin
                lo = 411; hi = 502;
            end else if (yy >= 259 && yy < 378) begin
                lo = 411; hi = 651;
            end else begin
                lo = 0; hi = 1;
            end
            for (int xx = lo; xx <= hi; xx++) begin
                k         = find(xx, yy);
                x         = 11'(xx);
                y         = 10'(yy);
                region_en = (k >= 0) ? tbl[k].en : 3'b111;
                tick();
                for (int i = 0; i < 3; i++) begin
                    if (rom_addr[i*15 +: 15] > max_a[i]) max_a[i] = rom_addr[i*15 +: 15];
                end
                if (k >= 0) begin
                    chk($sformatf("addr_v%0d", k), 64'(rom_addr[tbl[k].rg*15 +: 15]), 64'(tbl[k].addr));
                    chk($sformatf("p_addr0_v%0d", k), 64'(p_rom_addr[14:0]), 64'(tbl[k].p_addr0));
                end
                if (prev >= 0) begin
                    chk($sformatf("dav_v%0d", prev), 64'(dav), 64'(tbl[prev].dav));
                    chk($sformatf("rgb_v%0d", prev), 64'({r, g, b}), 64'(tbl[prev].rgb));
                    chk($sformatf("p_dav_v%0d", prev), 64'(p_dav), 64'(tbl[prev].p_dav));
                    chk($sformatf("p_rgb_v%0d", prev), 64'({p_r, p_g, p_b}), 64'(tbl[prev].p_rgb));
                end
                prev = k;
            end
        end
        chk("max_addr_r0", 64'(max_a[0]), 64'd12119);
        chk("max_addr_r1", 64'(max_a[1]), 64'd7743);
        chk("max_addr_r2", 64'(max_a[2]), 64'd28202);

`ifdef DRAW_BLINK_EN
        // Region 0 blinks with a two-frame half-period: visible, visible, hidden, hidden, visible.
        for (int f = 0; f < 5; f++) begin
            x         = 11'd300;
            y         = 10'd60;
            region_en = 3'b111;
            tick();
            tick();
            tick();
            chk($sformatf("blink_dav_f%0d", f), 64'(dav), (f == 2 || f == 3) ? 64'd0 : 64'd1);
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
